ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 91 +++++++++
 tb/tb_ram_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of one single-port synchronous RAM.
// Rotating priority, one access per cycle, read data returned a cycle later.
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [15:0]       conflict_cnt
);

    logic        r_prio;
    logic        r_rv0;
    logic        r_rv1;
    logic [15:0] r_cnt;

    logic w_both;
    logic w_g0;
    logic w_g1;

    assign w_both = m0_req & m1_req;

    // A lone requester always wins; contention is settled by r_prio.
    assign w_g0 = ~rst & m0_req & (~m1_req | ~r_prio);
    assign w_g1 = ~rst & m1_req & (~m0_req |  r_prio);

    assign m0_gnt = w_g0;
    assign m1_gnt = w_g1;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (w_g0) begin
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (w_g1) begin
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
            r_rv0  <= 1'b0;
            r_rv1  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_g0) begin
                r_prio <= 1'b1;
            end else if (w_g1) begin
                r_prio <= 1'b0;
            end
            r_rv0 <= w_g0 & ~m0_we;
            r_rv1 <= w_g1 & ~m1_we;
            if (w_both && r_cnt != 16'hFFFF) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    // Reset landing on the return cycle kills the pending read at once.
    assign m0_rvalid = r_rv0 & ~rst;
    assign m1_rvalid = r_rv1 & ~rst;
    assign m0_rdata  = m0_rvalid ? ram_dout : '0;
    assign m1_rdata  = m1_rvalid ? ram_dout : '0;

    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: synchronous RAM model, per-cycle reference
// model check, and directed scenarios with literal expectations.
module tb_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0;
    logic          m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0;
    logic          m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [15:0]   conflict_cnt;

    int n_vec = 0;
    int n_err = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Environment RAM: read-before-write, data one cycle after address
    logic [DW-1:0] mem [1024];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
            mem_init = 1'b1;
        end
        ram_dout <= mem[ram_addr];
        if (ram_we) mem[ram_addr] = ram_din;
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    // Reference model: who should win, what RAM holds, what returns next
    int          m_prio = 0;
    int          m_cnt = 0;
    bit          m_rv [2] = '{0, 0};
    logic [31:0] m_rd [2] = '{0, 0};
    logic [31:0] m_mem [1024];
    int          win;
    bit          ewe;
    logic [31:0] ea;
    logic [31:0] ed;

    initial for (int i = 0; i < 1024; i++) m_mem[i] = 32'h1000_0000 + i;

    always @(negedge clk) begin
        win = -1;
        if (!rst) begin
            if (m0_req && m1_req) win = m_prio;
            else if (m0_req) win = 0;
            else if (m1_req) win = 1;
        end
        ewe = 0; ea = 0; ed = 0;
        if (win == 0) begin ewe = m0_we; ea = 32'(m0_addr); ed = m0_wdata; end
        if (win == 1) begin ewe = m1_we; ea = 32'(m1_addr); ed = m1_wdata; end

        chk("m0_gnt", 32'(m0_gnt), 32'(win == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(win == 1));
        chk("ram_we", 32'(ram_we), 32'(ewe));
        chk("ram_addr", 32'(ram_addr), ea);
        chk("ram_din", ram_din, ed);
        chk("m0_rvalid", 32'(m0_rvalid), 32'(m_rv[0] && !rst));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(m_rv[1] && !rst));
        chk("m0_rdata", m0_rdata, (m_rv[0] && !rst) ? m_rd[0] : 32'h0);
        chk("m1_rdata", m1_rdata, (m_rv[1] && !rst) ? m_rd[1] : 32'h0);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));

        if (rst) begin
            m_prio = 0; m_cnt = 0; m_rv[0] = 0; m_rv[1] = 0;
        end else begin
            if (m0_req && m1_req && m_cnt < 65535) m_cnt++;
            m_rv[0] = 0; m_rv[1] = 0;
            if (win >= 0) begin
                m_prio = 1 - win;
                if (ewe) m_mem[ea[AW-1:0]] = ed;
                else begin
                    m_rv[win] = 1;
                    m_rd[win] = m_mem[ea[AW-1:0]];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    initial begin
        tick(); tick();
        rst = 0;

        // Lone m0 read of word 4
        m0_req = 1; m0_addr = 10'h004;
        @(negedge clk);
        chk("t1_gnt", 32'(m0_gnt), 32'd1);
        chk("t1_addr", 32'(ram_addr), 32'h004);
        chk("t1_we", 32'(ram_we), 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("t1_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t1_rdata", m0_rdata, 32'h1000_0004);
        chk("t1_m1", {31'(m1_rdata), m1_rvalid}, 32'd0);

        // Contention alternates, starting with m0
        do_reset();
        m0_req = 1; m0_addr = 10'h020; m1_req = 1; m1_addr = 10'h021;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_gnt", {30'd0, m1_gnt, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        idle();
        @(negedge clk);
        chk("t2_cnt", 32'(conflict_cnt), 32'd4);
        chk("t2_rd1", m1_rdata, 32'h1000_0021);
        tick();

        // m1 write then m0 reads it back
        m1_req = 1; m1_we = 1; m1_addr = 10'h010; m1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t3_we", 32'(ram_we), 32'd1);
        chk("t3_din", ram_din, 32'hDEADBEEF);
        tick(); idle();
        m0_req = 1; m0_addr = 10'h010;
        @(negedge clk);
        chk("t3_norv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        tick(); idle();
        @(negedge clk);
        chk("t3_rdata", m0_rdata, 32'hDEADBEEF);

        // Back-to-back m0 reads, no bubbles
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            m0_req = 1; m0_addr = AW'(i);
            @(negedge clk);
            chk("t4_gnt", 32'(m0_gnt), 32'd1);
            if (i > 1) chk("t4_rv", m0_rdata, 32'h1000_0000 + i - 1);
            tick();
        end
        idle();
        @(negedge clk);
        chk("t4_rv3", m0_rdata, 32'h1000_0003);
        chk("t4_cnt", 32'(conflict_cnt), 32'd0);
        tick();

        // m0 requests then withdraws while m1 holds priority
        m0_req = 1; m1_req = 1; m1_addr = 10'h030;
        tick();
        m0_req = 0;
        @(negedge clk);
        chk("t5_nogrant0", 32'(m0_gnt), 32'd0);
        tick(); idle();

        // Reset cancels a pending m1 read
        m1_req = 1; m1_addr = 10'h005;
        tick();
        rst = 1;
        @(negedge clk);
        chk("t6_rv_rst", 32'(m1_rvalid), 32'd0);
        chk("t6_gnt_rst", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        tick(); rst = 0;
        m0_req = 1;
        @(negedge clk);
        chk("t6_prio", 32'(m0_gnt), 32'd1);
        chk("t6_cnt", 32'(conflict_cnt), 32'd0);
        chk("t6_rv", 32'(m1_rvalid), 32'd0);
        tick();

        // Saturation of the contention counter
        do_reset();
        m0_req = 1; m1_req = 1;
        for (int i = 0; i < 65540; i++) tick();
        @(negedge clk);
        chk("t7_sat", 32'(conflict_cnt), 32'h0000_FFFF);
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        chk("t7_hold", 32'(conflict_cnt), 32'h0000_FFFF);
        idle();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
